// File: rtl/strobe_ctrl_pkg.sv
// rtl/strobe_ctrl_pkg.sv - shared types and constants for the strobe sequencer
// State encoding, seeding constants and the seed byte selector.
package strobe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int          SEED_BYTES      = 16;
  localparam logic [31:0] SEED_ZERO_SUBST = 32'h9E3779B9;

  // Byte k of each 4-byte group is taken MSB first.
  function automatic logic [7:0] seed_byte(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/strobe_ctrl.sv
// rtl/strobe_ctrl.sv - command sequencer that seeds and gates one strobe instance
// Accepts a command, streams 16 seed bytes, then runs the strobe for a burst or until abort.
module strobe_ctrl
  import strobe_ctrl_pkg::*;
#(
  parameter int CTRL_PERIOD_W = 16,
  parameter int CTRL_JITTER_W = 8,
  parameter int BURST_W       = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cg,
  input  logic                     i_cmdValid,
  output logic                     o_cmdReady,
  input  logic [CTRL_PERIOD_W-1:0] i_cmdPeriodM1,
  input  logic [CTRL_JITTER_W-1:0] i_cmdJitter,
  input  logic [31:0]              i_cmdSeed,
  input  logic [BURST_W-1:0]       i_cmdBurst,
  input  logic                     i_abort,
  output logic [CTRL_PERIOD_W-1:0] o_ctrlPeriodM1,
  output logic [CTRL_JITTER_W-1:0] o_ctrlJitter,
  output logic [7:0]               o_jitterSeedByte,
  output logic                     o_jitterSeedValid,
  output logic                     o_strobeCg,
  input  logic                     i_strobe,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_aborted,
  output logic [BURST_W-1:0]       o_remaining
);

  state_t                   r_state;
  logic [3:0]               r_seedIdx;
  logic [31:0]              r_seed;
  logic                     r_burstZero;
  logic                     r_cgPrev;
  logic [CTRL_PERIOD_W-1:0] r_periodM1;
  logic [CTRL_JITTER_W-1:0] r_jitter;
  logic [7:0]               r_seedByte;
  logic                     r_seedValid;
  logic                     r_strobeCg;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_aborted;
  logic [BURST_W-1:0]       r_remaining;

  logic        w_cmdReady;
  logic        w_accept;
  logic [31:0] w_seedWord;
  logic        w_strobeHit;
  logic        w_seedLast;
  logic [3:0]  w_seedIdxNext;

  assign w_cmdReady    = (r_state == ST_IDLE);
  assign w_accept      = i_cmdValid && w_cmdReady && i_cg;
  assign w_seedWord    = (i_cmdSeed == 32'd0) ? SEED_ZERO_SUBST : i_cmdSeed;
  // The strobe output is registered behind our gate, so only a value produced
  // while the gate was open last cycle is a fresh pulse.
  assign w_strobeHit   = i_strobe && r_cgPrev;
  assign w_seedLast    = (r_seedIdx == 4'(SEED_BYTES - 1));
  assign w_seedIdxNext = r_seedIdx + 4'd1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_seedIdx   <= '0;
      r_seed      <= '0;
      r_burstZero <= 1'b0;
      r_cgPrev    <= 1'b0;
      r_periodM1  <= '0;
      r_jitter    <= '0;
      r_seedByte  <= '0;
      r_seedValid <= 1'b0;
      r_strobeCg  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_remaining <= '0;
    end else if (i_cg) begin
      r_cgPrev  <= r_strobeCg;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      if (i_abort && (r_state != ST_IDLE)) begin
        r_state     <= ST_IDLE;
        r_seedIdx   <= '0;
        r_seedByte  <= '0;
        r_seedValid <= 1'b0;
        r_strobeCg  <= 1'b0;
        r_busy      <= 1'b0;
        r_aborted   <= 1'b1;
        r_remaining <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              r_periodM1  <= i_cmdPeriodM1;
              r_jitter    <= i_cmdJitter;
              r_remaining <= i_cmdBurst;
              r_burstZero <= (i_cmdBurst == '0);
              r_seed      <= w_seedWord;
              r_seedIdx   <= '0;
              r_seedByte  <= seed_byte(w_seedWord, 2'd0);
              r_seedValid <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= ST_SEED;
            end
          end
          ST_SEED: begin
            if (w_seedLast) begin
              r_seedIdx   <= '0;
              r_seedByte  <= '0;
              r_seedValid <= 1'b0;
              r_strobeCg  <= 1'b1;
              r_state     <= ST_RUN;
            end else begin
              r_seedIdx  <= w_seedIdxNext;
              r_seedByte <= seed_byte(r_seed, w_seedIdxNext[1:0]);
            end
          end
          ST_RUN: begin
            if (w_strobeHit && !r_burstZero && (r_remaining != '0)) begin
              if (r_remaining == BURST_W'(1)) begin
                r_remaining <= '0;
                r_strobeCg  <= 1'b0;
                r_done      <= 1'b1;
                r_state     <= ST_DONE;
              end else begin
                r_remaining <= r_remaining - BURST_W'(1);
              end
            end
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_cmdReady        = w_cmdReady;
  assign o_ctrlPeriodM1    = r_periodM1;
  assign o_ctrlJitter      = r_jitter;
  assign o_jitterSeedByte  = r_seedByte;
  assign o_jitterSeedValid = r_seedValid;
  assign o_strobeCg        = r_strobeCg;
  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_aborted         = r_aborted;
  assign o_remaining       = r_remaining;

endmodule
